// File: rtl/pipe_control_unit_if.sv
// Handshake bundle between the pipeline control unit and the datapath / mult-div unit.
// The slave modport is the control unit; the master side drives Decode and the md handshake.
interface pipe_control_unit_if #(
    parameter int REG_W = 5
);
    logic [31:0]      insn_d;
    logic             valid_d;
    logic             branch_taken_x;
    logic             md_ready;
    logic             md_exception;
    logic             stall_fd;
    logic             flush_fd;
    logic             redirect_x;
    logic [4:0]       x_alu_op;
    logic             x_alu_inb_imm;
    logic [1:0]       x_fwd_a;
    logic [1:0]       x_fwd_b;
    logic             md_start_mult;
    logic             md_start_div;
    logic             m_dmem_we;
    logic             w_reg_we;
    logic [REG_W-1:0] w_reg_addr;
    logic [1:0]       w_wd_sel;
    logic [31:0]      w_status;

    modport slave (
        input  insn_d, valid_d, branch_taken_x, md_ready, md_exception,
        output stall_fd, flush_fd, redirect_x, x_alu_op, x_alu_inb_imm, x_fwd_a, x_fwd_b,
               md_start_mult, md_start_div, m_dmem_we, w_reg_we, w_reg_addr, w_wd_sel, w_status
    );

    modport master (
        output insn_d, valid_d, branch_taken_x, md_ready, md_exception,
        input  stall_fd, flush_fd, redirect_x, x_alu_op, x_alu_inb_imm, x_fwd_a, x_fwd_b,
               md_start_mult, md_start_div, m_dmem_we, w_reg_we, w_reg_addr, w_wd_sel, w_status
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined control for the 5-stage core: decode in D, bundles through D/X, X/M, M/W,
// load-use and mult/div stalls, redirect flushes and operand forwarding selects.
module pipe_control_unit #(
    parameter int REG_W   = 5,
    parameter int RSTATUS = 30,
    parameter int RRA     = 31
) (
    input logic                clock,
    input logic                reset,
    pipe_control_unit_if.slave bus
);
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] FN_MUL   = 5'b00110;
    localparam logic [4:0] FN_DIV   = 5'b00111;

    localparam logic [1:0] WD_MEM    = 2'b01;
    localparam logic [1:0] WD_PC1    = 2'b10;
    localparam logic [1:0] WD_STATUS = 2'b11;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_M     = 2'b01;
    localparam logic [1:0] FWD_W     = 2'b10;

    localparam logic [REG_W-1:0] REG_STATUS = REG_W'(RSTATUS);
    localparam logic [REG_W-1:0] REG_LINK   = REG_W'(RRA);

    typedef struct packed {
        logic             reg_we;
        logic [REG_W-1:0] dest;
        logic [1:0]       wd_sel;
        logic [4:0]       alu_op;
        logic             inb_imm;
        logic             dmem_we;
        logic             is_lw;
        logic             is_jump;
        logic             is_br;
        logic             is_mul;
        logic             is_div;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [2:0]       status;
    } ctrl_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    ctrl_t     dec, x_out, dx, xm, mw;
    md_state_t md_state;
    logic      md_start_mult_q, md_start_div_q;
    logic      redirect, load_use, md_hold, md_done, md_launch;

    logic [4:0]       opcode, alu_fn;
    logic [REG_W-1:0] rd, rs, rt;
    logic             unused_insn_bits;

    assign opcode = bus.insn_d[31:27];
    assign rd     = bus.insn_d[22 +: REG_W];
    assign rs     = bus.insn_d[17 +: REG_W];
    assign rt     = bus.insn_d[12 +: REG_W];
    assign alu_fn = bus.insn_d[6:2];
    // shamt and immediate bits are consumed by the datapath only
    assign unused_insn_bits = ^{bus.insn_d[11:7], bus.insn_d[1:0]};

    always_comb begin
        dec = '0;
        if (bus.valid_d) begin
            case (opcode)
                OP_RTYPE: begin
                    dec.reg_we = 1'b1;
                    dec.dest   = rd;
                    dec.alu_op = alu_fn;
                    dec.src_a  = rs;
                    dec.src_b  = rt;
                    dec.is_mul = (alu_fn == FN_MUL);
                    dec.is_div = (alu_fn == FN_DIV);
                end
                OP_ADDI, OP_LW: begin
                    dec.reg_we  = 1'b1;
                    dec.dest    = rd;
                    dec.inb_imm = 1'b1;
                    dec.src_a   = rs;
                    dec.is_lw   = (opcode == OP_LW);
                    dec.wd_sel  = (opcode == OP_LW) ? WD_MEM : 2'b00;
                end
                OP_SW: begin
                    dec.dmem_we = 1'b1;
                    dec.inb_imm = 1'b1;
                    dec.src_a   = rs;
                    dec.src_b   = rd;
                end
                OP_J:  dec.is_jump = 1'b1;
                OP_JAL: begin
                    dec.is_jump = 1'b1;
                    dec.reg_we  = 1'b1;
                    dec.dest    = REG_LINK;
                    dec.wd_sel  = WD_PC1;
                end
                OP_JR: begin
                    dec.is_jump = 1'b1;
                    dec.src_a   = rd;
                end
                OP_BNE, OP_BLT: begin
                    dec.is_br = 1'b1;
                    dec.src_a = rd;
                    dec.src_b = rs;
                end
                default: dec = '0;
            endcase
            // r0 is hardwired: drop the write entirely so nothing downstream matches it
            if (dec.dest == '0) begin
                dec.reg_we = 1'b0;
                dec.wd_sel = 2'b00;
            end
        end
    end

    // md_ready only counts while a mul/div is actually occupying Execute
    assign md_done  = (md_state == MD_BUSY) && bus.md_ready;
    assign md_hold  = (md_state == MD_BUSY) && !bus.md_ready;
    assign redirect = dx.is_jump || (dx.is_br && bus.branch_taken_x);
    assign load_use = dx.is_lw && dx.reg_we &&
                      ((dec.src_a == dx.dest) || (dec.src_b == dx.dest));
    assign md_launch = !md_hold && !redirect && !load_use && (dec.is_mul || dec.is_div);

    always_comb begin
        x_out = dx;
        if (md_done && bus.md_exception) begin
            x_out.reg_we = 1'b1;
            x_out.dest   = REG_STATUS;
            x_out.wd_sel = WD_STATUS;
            x_out.status = dx.is_mul ? 3'd4 : 3'd5;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input ctrl_t m, input ctrl_t w);
        if (src == '0)                    return FWD_RF;
        if (m.reg_we && (m.dest == src))  return FWD_M;
        if (w.reg_we && (w.dest == src))  return FWD_W;
        return FWD_RF;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            dx              <= '0;
            xm              <= '0;
            mw              <= '0;
            md_state        <= MD_IDLE;
            md_start_mult_q <= 1'b0;
            md_start_div_q  <= 1'b0;
        end else begin
            mw <= xm;
            xm <= md_hold ? '0 : x_out;
            if (!md_hold) dx <= (redirect || load_use) ? '0 : dec;
            md_start_mult_q <= md_launch && dec.is_mul;
            md_start_div_q  <= md_launch && dec.is_div;
            case (md_state)
                MD_IDLE: if (md_launch) md_state <= MD_BUSY;
                MD_BUSY: if (bus.md_ready && !md_launch) md_state <= MD_IDLE;
            endcase
        end
    end

    assign bus.stall_fd      = md_hold || (load_use && !redirect);
    assign bus.flush_fd      = redirect;
    assign bus.redirect_x    = redirect;
    assign bus.x_alu_op      = dx.alu_op;
    assign bus.x_alu_inb_imm = dx.inb_imm;
    assign bus.x_fwd_a       = fwd_sel(dx.src_a, xm, mw);
    assign bus.x_fwd_b       = fwd_sel(dx.src_b, xm, mw);
    assign bus.md_start_mult = md_start_mult_q;
    assign bus.md_start_div  = md_start_div_q;
    assign bus.m_dmem_we     = xm.dmem_we;
    assign bus.w_reg_we      = mw.reg_we;
    assign bus.w_reg_addr    = mw.dest;
    assign bus.w_wd_sel      = mw.wd_sel;
    assign bus.w_status      = {29'd0, mw.status};
endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios plus a randomized
// instruction stream checked against an instruction-level pipeline model.
module tb_pipe_control_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipe_control_unit_if #(.REG_W(5)) bus ();
    pipe_control_unit dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] op, rd, rs, rt, fn;
    } rec_t;

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int fn);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(fn), 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] insn);
        bus.insn_d  = insn;
        bus.valid_d = 1'b1;
    endtask

    task automatic idle_d();
        bus.insn_d  = 32'd0;
        bus.valid_d = 1'b0;
    endtask

    task automatic drain();
        idle_d();
        bus.branch_taken_x = 1'b0;
        bus.md_ready = 1'b0;
        bus.md_exception = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b0;
        drive(enc_i(5, 7, 1, 5));
        bus.md_ready = 1'b1;
        tick(); tick();
        outs = {bus.stall_fd, bus.flush_fd, bus.redirect_x, bus.x_alu_op, bus.x_alu_inb_imm,
                bus.x_fwd_a, bus.x_fwd_b, bus.md_start_mult, bus.md_start_div, bus.m_dmem_we,
                bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel, bus.w_status};
        checks++; if (outs !== 64'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        bus.md_ready = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (bus.x_alu_inb_imm !== 1'b1) begin failures++; $display("FAIL reset_addi_x got=%b exp=1", bus.x_alu_inb_imm); end
        idle_d();
        tick();
        checks++; if (bus.w_reg_we !== 1'b0) begin failures++; $display("FAIL reset_early_we got=%b exp=0", bus.w_reg_we); end
        tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd7) begin failures++; $display("FAIL reset_addi_wb got=%b/%0d exp=1/7", bus.w_reg_we, bus.w_reg_addr); end
    endtask

    task automatic test_load_use();
        drive(enc_i(8, 3, 1, 4));
        tick();
        drive(enc_r(4, 3, 2, 0));
        #1;
        checks++; if (bus.stall_fd !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall_fd); end
        tick();
        checks++; if (bus.stall_fd !== 1'b0 || bus.x_alu_inb_imm !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b/%b exp=0/0", bus.stall_fd, bus.x_alu_inb_imm); end
        tick();
        idle_d();
        #1;
        checks++; if (bus.x_fwd_a !== 2'b10 || bus.x_fwd_b !== 2'b00) begin failures++; $display("FAIL lu_fwd got=%b/%b exp=10/00", bus.x_fwd_a, bus.x_fwd_b); end
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd3 || bus.w_wd_sel !== 2'b01) begin failures++; $display("FAIL lu_wb got=%b/%0d/%b exp=1/3/01", bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel); end
    endtask

    task automatic test_fwd_priority();
        drive(enc_i(5, 5, 1, 1)); tick();
        drive(enc_i(5, 5, 1, 2)); tick();
        drive(enc_r(6, 5, 5, 1)); tick();
        drive(enc_r(8, 5, 0, 2));
        #1;
        checks++; if (bus.x_fwd_a !== 2'b01 || bus.x_fwd_b !== 2'b01) begin failures++; $display("FAIL fwd_prio got=%b/%b exp=01/01", bus.x_fwd_a, bus.x_fwd_b); end
        checks++; if (bus.x_alu_op !== 5'd1) begin failures++; $display("FAIL fwd_aluop got=%0d exp=1", bus.x_alu_op); end
        tick();
        idle_d();
        #1;
        checks++; if (bus.x_fwd_a !== 2'b10 || bus.x_fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_w got=%b/%b exp=10/00", bus.x_fwd_a, bus.x_fwd_b); end
    endtask

    task automatic test_branch();
        int writes = 0;
        drive(enc_i(2, 1, 2, 0)); tick();
        drive(enc_i(5, 9, 1, 1));
        bus.branch_taken_x = 1'b1;
        #1;
        checks++; if (bus.redirect_x !== 1'b1 || bus.flush_fd !== 1'b1 || bus.stall_fd !== 1'b0) begin failures++; $display("FAIL br_taken got=%b/%b/%b exp=1/1/0", bus.redirect_x, bus.flush_fd, bus.stall_fd); end
        tick();
        idle_d();
        bus.branch_taken_x = 1'b0;
        #1;
        checks++; if (bus.redirect_x !== 1'b0 || bus.flush_fd !== 1'b0) begin failures++; $display("FAIL br_one_cycle got=%b/%b exp=0/0", bus.redirect_x, bus.flush_fd); end
        repeat (3) begin tick(); writes += int'(bus.w_reg_we); end
        checks++; if (writes != 0) begin failures++; $display("FAIL br_flushed_write got=%0d exp=0", writes); end
        drive(enc_i(6, 1, 2, 0)); tick();
        drive(enc_i(5, 9, 1, 1));
        #1;
        checks++; if (bus.redirect_x !== 1'b0 || bus.flush_fd !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%b/%b exp=0/0", bus.redirect_x, bus.flush_fd); end
        tick(); idle_d(); tick(); tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd9) begin failures++; $display("FAIL br_fallthru_wb got=%b/%0d exp=1/9", bus.w_reg_we, bus.w_reg_addr); end
    endtask

    task automatic test_jal();
        drive(enc_i(3, 0, 0, 0)); tick();
        idle_d();
        #1;
        checks++; if (bus.redirect_x !== 1'b1 || bus.flush_fd !== 1'b1) begin failures++; $display("FAIL jal_redirect got=%b/%b exp=1/1", bus.redirect_x, bus.flush_fd); end
        tick(); tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd31 || bus.w_wd_sel !== 2'b10) begin failures++; $display("FAIL jal_wb got=%b/%0d/%b exp=1/31/10", bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel); end
    endtask

    task automatic test_mult();
        int stalls = 0, starts = 0, redirs = 0, first_start = -1;
        drive(enc_r(10, 1, 2, 6)); tick();
        drive(enc_i(5, 11, 1, 3));
        for (int c = 0; c <= 17; c++) begin
            bus.md_ready = (c == 17);
            #1;
            stalls += int'(bus.stall_fd);
            redirs += int'(bus.redirect_x);
            if (bus.md_start_mult === 1'b1) begin starts++; if (first_start < 0) first_start = c; end
            tick();
        end
        bus.md_ready = 1'b0;
        idle_d();
        checks++; if (stalls != 17) begin failures++; $display("FAIL md_stall_cycles got=%0d exp=17", stalls); end
        checks++; if (starts != 1 || first_start != 0) begin failures++; $display("FAIL md_start_pulse got=%0d@%0d exp=1@0", starts, first_start); end
        checks++; if (redirs != 0) begin failures++; $display("FAIL md_redirect got=%0d exp=0", redirs); end
        tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd10 || bus.w_wd_sel !== 2'b00) begin failures++; $display("FAIL md_mul_wb got=%b/%0d/%b exp=1/10/00", bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel); end
        tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd11) begin failures++; $display("FAIL md_follow_wb got=%b/%0d exp=1/11", bus.w_reg_we, bus.w_reg_addr); end
    endtask

    task automatic test_div_exception();
        drive(enc_r(12, 1, 2, 7)); tick();
        idle_d();
        bus.md_ready = 1'b1;
        bus.md_exception = 1'b1;
        #1;
        checks++; if (bus.md_start_div !== 1'b1 || bus.stall_fd !== 1'b0) begin failures++; $display("FAIL div_zero_busy got=%b/%b exp=1/0", bus.md_start_div, bus.stall_fd); end
        tick();
        bus.md_ready = 1'b0;
        bus.md_exception = 1'b0;
        tick();
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd30 || bus.w_wd_sel !== 2'b11 || bus.w_status !== 32'd5)
            begin failures++; $display("FAIL div_exc_wb got=%b/%0d/%b/%0d exp=1/30/11/5", bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel, bus.w_status); end
    endtask

    task automatic test_back_to_back();
        drive(enc_r(13, 1, 2, 6)); tick();
        drive(enc_r(14, 1, 2, 7));
        #1;
        checks++; if (bus.stall_fd !== 1'b1 || bus.md_start_mult !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b/%b exp=1/1", bus.stall_fd, bus.md_start_mult); end
        tick();
        bus.md_ready = 1'b1;
        #1;
        checks++; if (bus.md_start_div !== 1'b0) begin failures++; $display("FAIL b2b_div_early got=%b exp=0", bus.md_start_div); end
        tick();
        idle_d();
        bus.md_exception = 1'b1;
        #1;
        checks++; if (bus.md_start_div !== 1'b1 || bus.md_start_mult !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/0", bus.md_start_div, bus.md_start_mult); end
        tick();
        bus.md_ready = 1'b0;
        bus.md_exception = 1'b0;
        checks++; if (bus.w_reg_we !== 1'b1 || bus.w_reg_addr !== 5'd13 || bus.w_status !== 32'd0) begin failures++; $display("FAIL b2b_mul_wb got=%b/%0d/%0d exp=1/13/0", bus.w_reg_we, bus.w_reg_addr, bus.w_status); end
        tick();
        checks++; if (bus.w_reg_addr !== 5'd30 || bus.w_status !== 32'd5) begin failures++; $display("FAIL b2b_div_wb got=%0d/%0d exp=30/5", bus.w_reg_addr, bus.w_status); end
    endtask

    task automatic test_reset_busy();
        int writes = 0;
        drive(enc_r(15, 1, 2, 6)); tick();
        idle_d(); tick();
        reset = 1'b0; tick();
        reset = 1'b1;
        bus.md_ready = 1'b1;
        #1;
        checks++; if (bus.stall_fd !== 1'b0 || bus.md_start_mult !== 1'b0) begin failures++; $display("FAIL rstbusy_idle got=%b/%b exp=0/0", bus.stall_fd, bus.md_start_mult); end
        tick();
        bus.md_ready = 1'b0;
        repeat (3) begin tick(); writes += int'(bus.w_reg_we); end
        checks++; if (writes != 0) begin failures++; $display("FAIL rstbusy_stale_write got=%0d exp=0", writes); end
    endtask

    // instruction-level view of the pipeline, straight from the ISA rules
    function automatic rec_t mk(input logic [31:0] i, input logic v);
        return '{v: v, op: i[31:27], rd: i[26:22], rs: i[21:17], rt: i[16:12], fn: i[6:2]};
    endfunction
    function automatic logic [4:0] dest_of(input rec_t r);
        if (!r.v) return 5'd0;
        if (r.op == 5'd0 || r.op == 5'd5 || r.op == 5'd8) return r.rd;
        if (r.op == 5'd3) return 5'd31;
        return 5'd0;
    endfunction
    function automatic logic [4:0] src1_of(input rec_t r);
        if (!r.v) return 5'd0;
        if (r.op == 5'd0 || r.op == 5'd5 || r.op == 5'd8 || r.op == 5'd7) return r.rs;
        if (r.op == 5'd2 || r.op == 5'd6 || r.op == 5'd4) return r.rd;
        return 5'd0;
    endfunction
    function automatic logic [4:0] src2_of(input rec_t r);
        if (!r.v) return 5'd0;
        if (r.op == 5'd0) return r.rt;
        if (r.op == 5'd7) return r.rd;
        if (r.op == 5'd2 || r.op == 5'd6) return r.rs;
        return 5'd0;
    endfunction
    function automatic logic [1:0] exp_fwd(input logic [4:0] s, input rec_t m, input rec_t w);
        if (s == 5'd0) return 2'b00;
        if (dest_of(m) == s) return 2'b01;
        if (dest_of(w) == s) return 2'b10;
        return 2'b00;
    endfunction

    task automatic gen(output logic [31:0] insn, output logic v);
        int k = $urandom_range(0, 5);
        int a = $urandom_range(0, 3), b = $urandom_range(0, 3), c = $urandom_range(0, 3);
        v = 1'b1;
        case (k)
            0: insn = enc_r(a, b, c, $urandom_range(0, 5));
            1: insn = enc_i(5, a, b, $urandom_range(0, 100));
            2: insn = enc_i(8, a, b, $urandom_range(0, 100));
            3: insn = enc_i(7, a, b, $urandom_range(0, 100));
            4: insn = enc_i(31, a, b, 0);
            default: begin insn = enc_i(8, a, b, 0); v = 1'b0; end
        endcase
    endtask

    task automatic test_random();
        rec_t x = '0, m = '0, w = '0, d;
        logic [31:0] cur;
        logic curv, st;
        logic [4:0] wd;
        gen(cur, curv);
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.insn_d = cur;
            bus.valid_d = curv;
            #1;
            d = mk(cur, curv);
            st = x.v && x.op == 5'd8 && x.rd != 0 && (src1_of(d) == x.rd || src2_of(d) == x.rd);
            wd = dest_of(w);
            checks++; if (bus.stall_fd !== st) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_fd, st); end
            checks++; if (bus.x_fwd_a !== exp_fwd(src1_of(x), m, w) || bus.x_fwd_b !== exp_fwd(src2_of(x), m, w))
                begin failures++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.x_fwd_a, bus.x_fwd_b, exp_fwd(src1_of(x), m, w), exp_fwd(src2_of(x), m, w)); end
            checks++; if (bus.w_reg_we !== (wd != 0) || (wd != 0 && (bus.w_reg_addr !== wd || bus.w_wd_sel !== ((w.op == 5'd8) ? 2'b01 : 2'b00))))
                begin failures++; $display("FAIL rnd_wb cyc=%0d got=%b/%0d/%b exp_addr=%0d", cyc, bus.w_reg_we, bus.w_reg_addr, bus.w_wd_sel, wd); end
            checks++; if (bus.m_dmem_we !== (m.v && m.op == 5'd7)) begin failures++; $display("FAIL rnd_dmem cyc=%0d got=%b", cyc, bus.m_dmem_we); end
            checks++; if (bus.x_alu_inb_imm !== (x.v && (x.op == 5'd5 || x.op == 5'd8 || x.op == 5'd7)) ||
                          bus.x_alu_op !== ((x.v && x.op == 5'd0) ? x.fn : 5'd0))
                begin failures++; $display("FAIL rnd_xctl cyc=%0d got=%b/%0d", cyc, bus.x_alu_inb_imm, bus.x_alu_op); end
            tick();
            w = m;
            m = x;
            x = st ? rec_t'('0) : d;
            if (!st) gen(cur, curv);
        end
        idle_d();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_d();
        bus.branch_taken_x = 1'b0;
        bus.md_ready = 1'b0;
        bus.md_exception = 1'b0;
        #1;
        test_reset();          drain();
        test_load_use();       drain();
        test_fwd_priority();   drain();
        test_branch();         drain();
        test_jal();            drain();
        test_mult();           drain();
        test_div_exception();  drain();
        test_back_to_back();   drain();
        test_reset_busy();     drain();
        test_random();         drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined control unit for the 5-stage processor: decodes the instruction in Decode and carries its control bundle through D/X, X/M and M/W registers. It detects load-use and multiply/divide hazards, runs the mult/div start/wait handshake, resolves redirect flushes and generates forwarding selects. It sits beside the datapath pipeline registers and replaces single-cycle, purely combinational control decode.

## Interface
- REG_W, 5, register address width
- RSTATUS, 30, register written with exception status
- RRA, 31, link register written by jal

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clears all stage registers to bubbles
- insn_d  in  32  instruction in Decode
- valid_d  in  1  insn_d is a real instruction
- branch_taken_x  in  1  datapath compare result for the branch in Execute
- md_ready  in  1  mult/div result ready, single-cycle pulse
- md_exception  in  1  qualifies md_ready; overflow or divide-by-zero
- stall_fd  out  1  hold PC and F/D register
- flush_fd  out  1  replace F/D contents with a bubble
- redirect_x  out  1  PC takes the target computed in Execute
- x_alu_op  out  5  ALU op in Execute: R-type ALUop field, else 00000
- x_alu_inb_imm  out  1  ALU B operand is sign-extended imm17
- x_fwd_a, x_fwd_b  out  2 each  operand source: 00 regfile, 01 M result, 10 W result
- md_start_mult, md_start_div  out  1 each  one-cycle start pulse
- m_dmem_we  out  1  data-memory write in Memory
- w_reg_we  out  1  regfile write enable
- w_reg_addr  out  REG_W  regfile write address
- w_wd_sel  out  2  write data: 00 ALU/md, 01 dmem, 10 PC+1, 11 status
- w_status  out  32  status value for w_wd_sel=11

## Operation
- Field layout: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], ALUop [6:2], imm [16:0].
- Opcode decode:
  - 00000 R-type; ALUop 00110 = mul, 00111 = div
  - 00101 addi; 00111 sw; 01000 lw
  - 00001 j; 00011 jal; 00100 jr
  - 00010 bne; 00110 blt
  - Any other opcode: bubble (no writes).
- Sources read per instruction:
  - R-type: rs, rt
  - addi, lw: rs
  - sw: rs, plus rd as store data
  - bne, blt: rd, rs
  - jr: rd
- Register writes:
  - R-type, addi, lw: write rd.
  - jal: writes RRA with PC+1 (w_wd_sel = 10).
- Bubble: all write enables 0, all other control outputs 0. Destination register 0 never asserts w_reg_we.
- Load-use hazard: Execute holds lw with rd ≠ 0 and rd equals any source of the valid Decode instruction.
  - Assert stall_fd for one cycle.
  - Insert a bubble into D/X.
- Redirect: asserted in Execute for j, jal and jr, and for bne/blt when branch_taken_x = 1.
  - Assert redirect_x and flush_fd.
  - Load D/X with a bubble.
- Forwarding, for each Execute source ≠ 0:
  - Select 01 if the M stage writes it; else 10 if the W stage writes it; else 00.
  - M has priority over W.
  - A source matching an M-stage lw never occurs, because the load-use stall prevents it.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE→BUSY when a valid mul/div enters Execute. Pulse the matching md_start_* for exactly that first cycle.
  - In BUSY, hold F/D and D/X (stall_fd = 1), send bubbles into X/M, and keep redirect_x = 0.
  - BUSY→IDLE on md_ready. The mul/div bundle advances to M that cycle.
  - With md_exception = 1, the bundle is rewritten: destination RSTATUS, w_wd_sel = 11, w_status = 4 for mul or 5 for div.
  - addi overflow is out of scope.

## Timing
- After reset (reset = 0 at a clock edge), every output is 0 and the FSM is in IDLE; this holds while reset is low.
- Decode→W latency is 3 cycles (D/X, X/M, M/W), plus stall cycles.
- stall_fd, flush_fd, redirect_x and x_fwd_* are combinational from the current stage registers. All other outputs are registered.
- Redirect and load-use in the same cycle: redirect wins. No stall; D is flushed.
- md_ready in the same cycle as the start pulse is legal: zero BUSY cycles, one-cycle total occupancy.
- A second mul/div arriving directly behind a first waits in D until the FSM returns to IDLE.
- Reset mid-BUSY: FSM goes to IDLE. A md_ready arriving after reset is ignored.
- valid_d = 0 is treated as a bubble and never causes a stall.

## Test plan
- Reset: drive reset = 0 for 2 cycles with an addi in D. Every output must be 0; release reset, and the addi writes rd 3 cycles later.
- Load-use: lw r3 followed by add r4,r3,r2. Exactly one stall_fd cycle, one bubble, then x_fwd_a = 10 for the add.
- Forwarding priority: addi r5 ×2 back-to-back, then add r6,r5,r5. x_fwd_a = x_fwd_b = 01 (newest value).
- Branch: bne with branch_taken_x = 1. redirect_x and flush_fd high for one cycle, no write from the flushed instructions; with branch_taken_x = 0, no flush.
- Mult/div: mul with md_ready after 17 cycles. md_start_mult pulses once, stall_fd is high for 17 cycles, then rd is written; a div with md_exception writes r30 with w_status = 5.
- jal: w_reg_addr = 31, w_wd_sel = 10, redirect_x high in Execute.
